// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Holds the PLL in reset and watches its LOCKED output. The divided-clock
//   domain is released only after lock has been continuously present for
//   STABLE_CYCLES. If the lock is lost or never arrives, the PLL is reset
//   again. After MAX_RETRIES failed attempts the sequencer parks in a sticky
//   FAULT state.
//
// Ports
//   clk_in        raw board clock (the same net that feeds clock_divider)
//   rst_n         asynchronous active-low reset
//   locked_in     PLL LOCKED, asynchronous; synchronized internally
//   soft_rst_req  one-cycle synchronous request to restart the sequence
//   pll_rst       PLL RST pin, active high
//   sys_rst_n     active-low reset for downstream logic (registered release)
//   ready         high only while running
//   fault         sticky: retries exhausted
//   retry_cnt     failed lock attempts in the current sequence
//   lock_loss_cnt (LOCK_LOSS_COUNT_EN only) saturating count of lock losses in RUN
//
// Build option
//   `define LOCK_LOSS_COUNT_EN  adds the lock_loss_cnt output and counter.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                             clk_in,
  input  logic                             rst_n,
  input  logic                             locked_in,
  input  logic                             soft_rst_req,
  output logic                             pll_rst,
  output logic                             sys_rst_n,
  output logic                             ready,
  output logic                             fault,
`ifdef LOCK_LOSS_COUNT_EN
  output logic [7:0]                       lock_loss_cnt,
`endif
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int RW      = $clog2(MAX_RETRIES + 1);
  localparam int MAX_AB  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_ALL = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  // Terminal compares happen one count early because the counter starts at 0
  // on state entry and the transition itself consumes the final cycle.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [RW-1:0]          retry_q, retry_d, retry_inc;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   locked_s;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign retry_inc = retry_q + RW'(1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], locked_in};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q + CNT_W'(1);

    if (soft_rst_req) begin
      state_d = ST_PLL_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RESET: if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RESET;
          end
        end
        // A dropout here is a lock glitch, not a failed attempt: go back to
        // waiting without touching retry_q.
        ST_STABILIZE: begin
          if (!locked_s)                  state_d = ST_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)  state_d = ST_RUN;
        end
        ST_RUN:   if (!locked_s) state_d = ST_PLL_RESET;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_PLL_RESET;
      endcase
    end

    if (state_d == ST_RUN) retry_d = '0;

    // The shared counter restarts on every entry (including a soft restart
    // of PLL_RESET) and freezes in the states that never compare it.
    if (soft_rst_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = cnt_q;
    end

    // Outputs are registered from the next state so they change together
    // with the state register, except the release of sys_rst_n/ready, which
    // waits one extra cycle after RUN is entered.
    pll_rst_d   = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    ready_d     = (state_q == ST_RUN) && (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

`ifdef LOCK_LOSS_COUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] llc_q, llc_d;
  logic       lost_lock;

  // Soft restart has priority, so a coincident request is not a lock loss.
  assign lost_lock = (state_q == ST_RUN) && !locked_s && !soft_rst_req;
  assign llc_d     = lost_lock ? sat_inc8(llc_q) : llc_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) llc_q <= '0;
    else        llc_q <= llc_d;
  end

  assign lock_loss_cnt = llc_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 16;
  localparam int STABLE_CYCLES  = 1024;
  localparam int LOCK_TIMEOUT   = 100;
  localparam int MAX_RETRIES    = 3;

`ifdef LOCK_LOSS_COUNT_EN
  localparam logic [7:0] LLC_MASK = 8'hFF;
`else
  localparam logic [7:0] LLC_MASK = 8'h00;
`endif

  // Observed vector: {lock_loss_cnt, pll_rst, sys_rst_n, ready, fault, retry_cnt[1:0]}
  localparam logic [5:0] O_RST  = 6'b100000;
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_RUN  = 6'b011000;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       locked_in;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  always #5 clk_in = ~clk_in;

  pll_reset_sequencer #(
    .SYNC_STAGES   (SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .locked_in    (locked_in),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fault        (fault),
`ifdef LOCK_LOSS_COUNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .retry_cnt    (retry_cnt)
  );

  typedef struct {
    string       tag;
    int          due;
    logic [13:0] v;
  } exp_t;

  exp_t       sb[$];
  int         cyc    = 0;
  int         total  = 0;
  int         passed = 0;
  logic [7:0] llc_exp = 8'd0;

  function automatic logic [13:0] obs();
`ifdef LOCK_LOSS_COUNT_EN
    return {lock_loss_cnt, pll_rst, sys_rst_n, ready, fault, retry_cnt};
`else
    return {8'd0, pll_rst, sys_rst_n, ready, fault, retry_cnt};
`endif
  endfunction

  task automatic push(input string tag, input int off, input logic [5:0] v6);
    exp_t e;
    e.tag = tag;
    e.due = cyc + off;
    e.v   = {llc_exp & LLC_MASK, v6};
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [13:0] o;
    o = obs();
    total++;
    assert (o === e.v) passed++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", e.tag, o, e.v, cyc);
  endtask

  task automatic scan();
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    scan();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int t0;
    rst_n        = 1'b1;
    locked_in    = 1'b0;
    soft_rst_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push("reset_init", 0, O_RST);
    scan();
    push("reset_hold", 3, O_RST);
    run(3);

    // Power-up: PLL reset for 16 cycles, lock 40 cycles after release.
    rst_n = 1'b1;
    push("pll_rst_15", 15, O_RST);
    push("pll_rst_off_16", 16, O_IDLE);
    run(40);
    locked_in = 1'b1;
    push("release_minus1", 1027, O_IDLE);
    push("release", 1028, O_RUN);
    push("run_hold", 1033, O_RUN);
    run(1033);

    // Lock loss in RUN, then no relock: three timeouts into FAULT.
    locked_in = 1'b0;
    push("lockloss_t2", 2, O_RUN);
    llc_exp = 8'd1;
    push("lockloss_drop", 3, O_RST);
    push("lockloss_pll_18", 18, O_RST);
    push("lockloss_pll_19", 19, O_IDLE);
    push("timeout1_pre", 118, O_IDLE);
    push("timeout1", 119, 6'b100001);
    push("timeout2_pre", 234, 6'b000001);
    push("timeout2", 235, 6'b100010);
    push("timeout3_pre", 350, 6'b000010);
    push("fault", 351, 6'b100111);
    push("fault_hold", 851, 6'b100111);
    run(851);

    // Soft reset out of FAULT.
    soft_rst_req = 1'b1;
    push("soft_from_fault", 1, O_RST);
    run(1);
    soft_rst_req = 1'b0;
    run(16);

    // Relock with a one-cycle glitch ~500 cycles into stabilization.
    locked_in = 1'b1;
    push("glitch_retry0", 503, O_IDLE);
    push("glitch_no_early_release", 1028, O_IDLE);
    push("glitch_release_pre", 1528, O_IDLE);
    push("glitch_release", 1529, O_RUN);
    run(500);
    locked_in = 1'b0;
    run(1);
    locked_in = 1'b1;
    run(1030);

    // Soft reset from RUN, then another one on the STABILIZE terminal count.
    soft_rst_req = 1'b1;
    push("soft_from_run", 1, O_RST);
    push("stab_before_term", 1041, O_IDLE);
    run(1);
    soft_rst_req = 1'b0;
    run(1040);
    soft_rst_req = 1'b1;
    push("soft_at_term", 1, O_RST);
    push("soft_at_term_hold", 2, O_RST);
    run(1);
    soft_rst_req = 1'b0;
    push("rerelease_pre", 1041, O_IDLE);
    push("rerelease", 1042, O_RUN);
    run(1045);

    // Asynchronous reset for half a clock period while running.
    t0 = cyc;
    #1 rst_n = 1'b0;
    llc_exp = 8'd0;
    #2;
    push("async_reset", 0, O_RST);
    scan();
    #3 rst_n = 1'b1;
    push("post_async_reset", 1, O_RST);
    run(1);

    if (sb.size() != 0 || cyc != t0 + 1) begin
      total++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
